// File: rtl/i2c_byte_master.sv
// i2c_byte_master: I2C master bit/byte engine driving open-drain SCL/SDA from START/STOP/WRITE/READ commands.
// Define I2C_CLK_STRETCH_EN to hold each Q1 until the slave releases SCL.
module i2c_byte_master #(
    parameter int CLK_DIV    = 125,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [2:0]            cmd_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  ack_o,
    output logic                  busy_o,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_o,
    output logic                  sda_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [2:0] C_START = 3'd0, C_STOP = 3'd1, C_WRITE = 3'd2, C_RACK = 3'd3, C_RNAK = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_BIT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            qtr_q, qtr_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [2:0]            cmd_q, cmd_d;
    logic [DATA_WIDTH-1:0] sh_q, sh_d, rdata_q, rdata_d;
    logic                  scl_q, scl_d, sda_q, sda_d, err_q, err_d, ack_q, ack_d, busy_q, busy_d;
    logic                  ready, acc, legal, active, tick, hold, last_bit;

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] scl_sync_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) scl_sync_q <= 2'b11;
        else       scl_sync_q <= {scl_sync_q[0], scl_i};
    end
    assign hold = active && qtr_q == 2'd1 && cnt_q == '0 && !scl_sync_q[1];
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign hold       = 1'b0;
`endif

    assign ready    = state_q == S_IDLE || state_q == S_DONE;
    assign acc      = cmd_valid_i && ready;
    assign legal    = cmd_i == C_START || (busy_q && cmd_i <= C_RNAK);
    assign active   = state_q == S_START || state_q == S_STOP || state_q == S_BIT;
    assign tick     = active && !hold && cnt_q == CW'(CLK_DIV - 1);
    assign last_bit = bit_q == BW'(DATA_WIDTH);

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        cmd_d   = cmd_q;
        sh_d    = sh_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        busy_d  = busy_q;
        err_d   = 1'b0;
        scl_d   = scl_q;
        sda_d   = sda_q;
        // The accept cycle is the first count of Q0, so done lands exactly 4*CLK_DIV per four quarters later.
        cnt_d   = ((active || (acc && legal)) && !tick && !hold) ? cnt_q + 1'b1 : '0;
        if (acc) begin
            state_d = !legal ? S_DONE : cmd_i == C_START ? S_START : cmd_i == C_STOP ? S_STOP : S_BIT;
            err_d   = !legal;
            qtr_d   = '0;
            bit_d   = '0;
            cmd_d   = legal ? cmd_i : cmd_q;
            sh_d    = legal ? data_i : sh_q;
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end else if (tick) begin
            qtr_d = qtr_q + 2'd1;
            if (state_q == S_BIT && qtr_q == 2'd2 && !last_bit) sh_d = {sh_q[DATA_WIDTH-2:0], sda_i};
            if (state_q == S_BIT && qtr_q == 2'd2 && last_bit && cmd_q == C_WRITE) ack_d = !sda_i;
            if (state_q == S_BIT && qtr_q == 2'd3 && !last_bit) bit_d = bit_q + 1'b1;
            if (qtr_q == 2'd3 && (state_q != S_BIT || last_bit)) begin
                state_d = S_DONE;
                busy_d  = state_q == S_START ? 1'b1 : state_q == S_STOP ? 1'b0 : busy_q;
                rdata_d = (state_q == S_BIT && cmd_q != C_WRITE) ? sh_q : rdata_q;
            end
        end
        if (state_d == S_START) begin
            scl_d = qtr_d == 2'd1 ? 1'b1 : qtr_d == 2'd3 ? 1'b0 : scl_q;
            sda_d = qtr_d == 2'd0 ? 1'b1 : qtr_d == 2'd2 ? 1'b0 : sda_q;
        end
        if (state_d == S_STOP) begin
            scl_d = qtr_d == 2'd0 ? 1'b0 : qtr_d == 2'd1 ? 1'b1 : scl_q;
            sda_d = qtr_d == 2'd0 ? 1'b0 : qtr_d == 2'd2 ? 1'b1 : sda_q;
        end
        if (state_d == S_BIT) begin
            scl_d = qtr_d == 2'd1 || qtr_d == 2'd2;
            if (qtr_d == 2'd0) sda_d = bit_d != BW'(DATA_WIDTH) ? (cmd_d != C_WRITE || sh_d[DATA_WIDTH-1]) : cmd_d != C_RACK;
        end
        if (state_q == S_BIT && state_d == S_DONE) sda_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            qtr_q   <= '0;
            bit_q   <= '0;
            cmd_q   <= '0;
            sh_q    <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            cmd_q   <= cmd_d;
            sh_q    <= sh_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            scl_q   <= scl_d;
            sda_q   <= sda_d;
        end
    end

    assign cmd_ready_o = ready;
    assign done_o      = state_q == S_DONE;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign ack_o       = ack_q;
    assign busy_o      = busy_q;
    assign scl_o       = scl_q;
    assign sda_o       = sda_q;
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: randomized command sequences against an open-drain I2C slave model
// and a transaction-level scoreboard of latency, flags, bus events and transferred bytes.
module tb_i2c_byte_master;
    localparam int CD = 4;

    logic       clk = 1'b0, rst = 1'b1;
    logic [2:0] cmd_i = '0;
    logic       cmd_valid_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       cmd_ready_o, done_o, err_o, ack_o, busy_o, scl_o, sda_o;
    logic [7:0] rdata_o;
    logic       scl_w, sda_w;

    logic       slv_read = 1'b0, slv_ack = 1'b1;
    logic [7:0] slv_tx = '0;
    logic       slv_sda, slv_scl_p, slv_sda_p, slv_in, slv_mack;
    logic [7:0] slv_sh, slv_rx;
    int         slv_bit, slv_starts, slv_rstarts, slv_stops;

    logic       m_busy, m_ack, m_sda;
    logic [7:0] m_rdata;
    int         m_starts, m_rstarts, m_stops;
    int         vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    assign scl_w = scl_o;
    assign sda_w = sda_o & slv_sda;

    i2c_byte_master #(.CLK_DIV(CD), .DATA_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .cmd_i(cmd_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .data_i(data_i), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .ack_o(ack_o), .busy_o(busy_o),
        .scl_i(scl_w), .sda_i(sda_w), .scl_o(scl_o), .sda_o(sda_o)
    );

    // Slave: detects START/STOP, samples bits on SCL rise, changes its SDA only while SCL is low.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            slv_sda <= 1'b1; slv_scl_p <= 1'b1; slv_sda_p <= 1'b1; slv_in <= 1'b0; slv_bit <= 0;
            slv_starts <= 0; slv_rstarts <= 0; slv_stops <= 0; slv_sh <= '0; slv_rx <= '0; slv_mack <= 1'b1;
        end else begin
            slv_scl_p <= scl_w;
            slv_sda_p <= sda_w;
            if (scl_w && slv_scl_p && slv_sda_p && !sda_w) begin
                slv_starts <= slv_starts + 1;
                if (slv_in) slv_rstarts <= slv_rstarts + 1;
                slv_in  <= 1'b1;
                slv_bit <= 0;
            end else if (scl_w && slv_scl_p && !slv_sda_p && sda_w) begin
                slv_stops <= slv_stops + 1;
                slv_in    <= 1'b0;
                slv_bit   <= 0;
            end else if (scl_w && !slv_scl_p) begin
                if (slv_bit < 8) slv_sh <= {slv_sh[6:0], sda_w};
                if (slv_bit == 7) slv_rx <= {slv_sh[6:0], sda_w};
                if (slv_bit == 8) slv_mack <= sda_w;
                slv_bit <= slv_bit == 8 ? 0 : slv_bit + 1;
            end
            if (!scl_w) slv_sda <= slv_read ? (slv_bit < 8 ? slv_tx[7 - slv_bit] : 1'b1) : (slv_bit == 8 ? !slv_ack : 1'b1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_ack = 1'b0; m_sda = 1'b1; m_rdata = '0;
        m_starts = 0; m_rstarts = 0; m_stops = 0;
    endtask

    // Issues one command, waits for done and scores it against the command-level model.
    task automatic do_cmd(input logic [2:0] c, input logic [7:0] d);
        int   n, lat;
        logic ok;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ok  = c == 3'd0 || (m_busy && c <= 3'd4);
        lat = !ok ? 1 : (c <= 3'd1) ? 4 * CD : 36 * CD;
        slv_read = ok && (c == 3'd3 || c == 3'd4);
        slv_tx   = d;
        chk("ready_before_accept", cmd_ready_o, 1);
        cmd_i = c; data_i = d; cmd_valid_i = 1'b1;
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        data_i = 8'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("ready_after_accept", cmd_ready_o, !ok);
            if (ok && n == 3) begin cmd_valid_i = 1'b1; cmd_i = 3'd1; end
            if (n == 4) cmd_valid_i = 1'b0;
        end while (!done_o && n < lat + 8);
        chk("latency", n, lat);
        chk("err", err_o, !ok);
        chk("ready_at_done", cmd_ready_o, 1);
        if (ok) begin
            if (c == 3'd0) begin
                if (m_busy) m_rstarts++;
                m_starts++; m_busy = 1'b1; m_sda = 1'b0;
            end else if (c == 3'd1) begin
                m_stops++; m_busy = 1'b0; m_sda = 1'b1;
            end else if (c == 3'd2) begin
                m_ack = slv_ack; m_sda = 1'b1;
                chk("slave_rx_byte", slv_rx, d);
            end else begin
                m_rdata = d; m_sda = 1'b1;
                chk("master_ack_bit", slv_mack, c == 3'd4);
            end
        end
        chk("busy", busy_o, m_busy);
        chk("ack", ack_o, m_ack);
        chk("rdata", rdata_o, m_rdata);
        chk("scl_between", scl_o, !m_busy);
        chk("sda_between", sda_o, m_sda);
        chk("bus_starts", slv_starts, m_starts);
        chk("bus_rstarts", slv_rstarts, m_rstarts);
        chk("bus_stops", slv_stops, m_stops);
        @(negedge clk);
        chk("done_one_cycle", done_o, 0);
    endtask

    initial begin
        int         n, nk;
        logic [2:0] c;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_scl", scl_o, 1);
        chk("rst_sda", sda_o, 1);
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_busy", busy_o, 0);
        rst = 1'b0;
        @(negedge clk);

        slv_ack = 1'b1;
        do_cmd(3'd0, 8'h00);
        do_cmd(3'd2, 8'h84);
        do_cmd(3'd1, 8'h00);
        do_cmd(3'd0, 8'h00);
        do_cmd(3'd2, 8'h85);
        do_cmd(3'd3, 8'hA5);
        do_cmd(3'd4, 8'h3C);
        do_cmd(3'd1, 8'h00);
        do_cmd(3'd0, 8'h00);
        slv_ack = 1'b0;
        do_cmd(3'd2, 8'h90);
        slv_ack = 1'b1;
        do_cmd(3'd0, 8'h00);
        do_cmd(3'd2, 8'h42);
        do_cmd(3'd1, 8'h00);
        do_cmd(3'd2, 8'h55);
        do_cmd(3'd6, 8'h00);

        for (int it = 0; it < 6; it++) begin
            do_cmd(3'($urandom_range(1, 7)), 8'($urandom));
            slv_ack = 1'b1;
            do_cmd(3'd0, 8'h00);
            slv_ack = 1'($urandom);
            do_cmd(3'd2, 8'($urandom));
            nk = $urandom_range(1, 3);
            for (int k = 0; k < nk; k++) begin
                n = $urandom_range(0, 4);
                if (n == 0) begin slv_ack = 1'($urandom); do_cmd(3'd2, 8'($urandom)); end
                if (n == 1) do_cmd(3'd3, 8'($urandom));
                if (n == 2) do_cmd(3'd4, 8'($urandom));
                if (n == 3) begin do_cmd(3'd0, 8'h00); slv_ack = 1'($urandom); do_cmd(3'd2, 8'($urandom)); end
                if (n == 4) begin c = 3'($urandom_range(5, 7)); do_cmd(c, 8'($urandom)); end
            end
            do_cmd(3'd1, 8'h00);
        end

        slv_ack = 1'b1;
        do_cmd(3'd0, 8'h00);
        slv_read = 1'b0;
        cmd_i = 3'd2; data_i = 8'h00; cmd_valid_i = 1'b1;
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        repeat (40) @(negedge clk);
        n = 0;
        while (scl_o !== 1'b0 && n < 16) begin @(negedge clk); n++; end
        chk("midwrite_scl_low", scl_o, 0);
        chk("midwrite_sda_low", sda_o, 0);
        rst = 1'b1;
        #1;
        chk("midrst_scl", scl_o, 1);
        chk("midrst_sda", sda_o, 1);
        chk("midrst_ready", cmd_ready_o, 1);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_done", done_o, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_cmd(3'd0, 8'h00);
        do_cmd(3'd2, 8'($urandom));
        do_cmd(3'd1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Synthesizable I2C master bit/byte engine. Sits directly upstream of the I2C slave BFM on the scl/sda wires.
- Converts single-byte commands from the IICMB-side sequencer into START, STOP, write-byte and read-byte bus waveforms.
- Drives SCL and SDA open-drain style and samples the returned ACK and read data.

Parameters:
- CLK_DIV, 125, system clocks per SCL quarter-period; must be >= 2.
- DATA_WIDTH, 8, bits per data byte.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous reset, active-high.
- cmd_i  input  3  command: 0 START, 1 STOP, 2 WRITE, 3 READ_ACK, 4 READ_NAK; 5-7 illegal.
- cmd_valid_i  input  1  command request.
- cmd_ready_o  output  1  engine idle, can accept a command.
- data_i  input  DATA_WIDTH  write byte; sampled at accept.
- done_o  output  1  one-cycle completion pulse.
- err_o  output  1  one-cycle pulse, coincident with done_o, for a rejected command.
- rdata_o  output  DATA_WIDTH  last read byte.
- ack_o  output  1  slave ACK for the last WRITE (1 = SDA seen low).
- busy_o  output  1  bus owned: set by START, cleared by STOP.
- scl_i  input  1  sensed SCL wire.
- sda_i  input  1  sensed SDA wire.
- scl_o  output  1  0 = drive SCL low, 1 = release.
- sda_o  output  1  0 = drive SDA low, 1 = release.

Behaviour:
- Reset values: scl_o=1, sda_o=1, cmd_ready_o=1, done_o=0, err_o=0, rdata_o=0, ack_o=0, busy_o=0.
- Reset asserted mid-operation releases both lines immediately and abandons the transfer.
- Quarter timer: counts 0..CLK_DIV-1 and produces a tick at CLK_DIV-1. It is held at 0 while idle.
- Handshake: command accepted when cmd_valid_i && cmd_ready_o.
  - cmd_ready_o drops the cycle after accept.
  - cmd_ready_o and done_o assert together, in the cycle after the final quarter tick.
  - Any cmd_valid_i without ready is ignored. No queueing.
- States: IDLE, START, STOP, BIT, DONE.
- START, four quarters:
  - Q0: sda=1, scl unchanged.
  - Q1: scl=1.
  - Q2: sda=0.
  - Q3: scl=0.
  - Legal whether busy_o is 0 or 1; a START while busy is a repeated START.
  - Sets busy_o at done.
- STOP, four quarters:
  - Q0: scl=0, sda=0.
  - Q1: scl=1.
  - Q2: sda=1.
  - Q3: hold.
  - Clears busy_o at done.
- BIT slot, four quarters:
  - Q0: scl=0, set sda.
  - Q1: scl=1.
  - Q2: scl=1; sda_i sampled on the Q2 tick.
  - Q3: scl=0.
  - A byte command is 9 slots, bit counter 0..8.
- WRITE: slots 0-7 drive data_i MSB first. Slot 8 releases SDA; ack_o <= ~sampled sda_i.
- READ_ACK / READ_NAK:
  - Slots 0-7 release SDA and shift samples in MSB first.
  - Slot 8 drives sda=0 (ACK) or sda=1 (NAK).
  - rdata_o updated at done.
- Latency from accept to done_o: START/STOP 4*CLK_DIV cycles; byte commands 36*CLK_DIV cycles.
- Rejected commands: STOP, WRITE or READ_* with busy_o=0, or codes 5-7.
  - done_o and err_o pulse 1 cycle after accept.
  - No bus activity; rdata_o, ack_o and busy_o unchanged.
- rdata_o and ack_o hold their value until the next successful command of the same kind.
- Between commands while busy: scl_o=0. sda_o holds its last value, except after a byte command, when it is released.

Optional Feature:
- Macro I2C_CLK_STRETCH_EN.
- Defined: in Q1 of any START/STOP/BIT quarter, the timer holds at 0 until scl_i is sampled high (two-flop synchronised), honouring slave clock stretching. Total latency grows by the stretch time.
- Undefined: scl_i is unused and timing is fixed as specified above.

Test Plan:
- Reset mid-WRITE (CLK_DIV=4) -> scl_o=sda_o=1 in the same cycle; cmd_ready_o=1; busy_o=0.
- START, WRITE 0x84 (addr 0x42, W), STOP with BFM ACKing, CLK_DIV=4:
  - done_o at +16, +144 and +16 cycles after each accept.
  - ack_o=1; BFM reports address 0x42, op WRITE.
  - busy_o 1 then 0.
- START, WRITE 0x85, READ_ACK with BFM data 0xA5, READ_NAK with 0x3C, STOP:
  - rdata_o = 0xA5 then 0x3C.
  - SDA low in slot 8 of the first read, released in slot 8 of the second.
  - BFM transfer_complete=1.
- WRITE to an unresponsive address (SDA floats high) -> ack_o=0, no err_o.
- Repeated START mid-transfer -> BFM detects repeated START; busy_o stays 1.
- WRITE with busy_o=0, and cmd_i=6 -> done_o+err_o 1 cycle after accept; scl_o/sda_o stay 1.
- With I2C_CLK_STRETCH_EN, BFM holds SCL low 50 cycles in bit 3 -> WRITE latency = 144+50(+sync) cycles; data intact.
